// File: rtl/arbitro_rr_2x1_pkg.sv
// Shared types and constants for the two-lane weighted round-robin arbiter.
package arbitro_rr_2x1_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } estado_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_L0   = 2'b01;
   localparam logic [1:0] GRANT_L1   = 2'b10;

   // One-hot grant seen by the outside world for a given FSM state.
   function automatic logic [1:0] grant_de(estado_t e);
      case (e)
         SERVE0:  return GRANT_L0;
         SERVE1:  return GRANT_L1;
         default: return GRANT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/arbitro_rr_2x1_if.sv
// Request lanes, output channel and grant of the 2:1 arbiter.
// master = the side that owns the lanes and the downstream sink, slave = arbiter.
interface arbitro_rr_2x1_if;
   logic [7:0] In0;
   logic       valid0;
   logic       ready0;
   logic [7:0] In1;
   logic       valid1;
   logic       ready1;
   logic [7:0] data_out;
   logic       outValid;
   logic       out_ready;
   logic [1:0] grant;

   modport master (
      output In0, valid0, In1, valid1, out_ready,
      input  ready0, ready1, data_out, outValid, grant
   );

   modport slave (
      input  In0, valid0, In1, valid1, out_ready,
      output ready0, ready1, data_out, outValid, grant
   );
endinterface

// File: rtl/arbitro_rr_2x1_registro_salida_rv.sv
// 8-bit ready/valid output register: loads on accept, drains when downstream takes it.
// data_out keeps its last value after draining; only the valid flag drops.
module registro_salida_rv (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] din,
   input  logic       out_ready,
   output logic [7:0] dout,
   output logic       out_valid
);

   // Load wins over drain so a word can leave and the next one enter on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout      <= 8'h00;
         out_valid <= 1'b0;
      end else if (load) begin
         dout      <= din;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/arbitro_rr_2x1.sv
// Two-lane weighted round-robin arbiter with bounded bursts in front of the lane mux.
//
// state  | meaning
// IDLE   | no lane granted, waiting for a valid
// SERVE0 | lane 0 granted, words accepted while output has space
// SERVE1 | lane 1 granted, words accepted while output has space
import arbitro_rr_2x1_pkg::*;

module arbitro_rr_2x1 #(
   parameter int BURST_MAX = 4
) (
   input logic            clk,
   input logic            reset,
   arbitro_rr_2x1_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BURST_MAX - 1);

   estado_t          state, state_nxt;
   logic             last, last_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       grant_q;
   logic             space;
   logic             accept0, accept1, load;
   logic             own_v, oth_v;
   estado_t          oth_s;
   logic [7:0]       din;

   assign space      = !bus.outValid | bus.out_ready;
   assign bus.ready0 = (state == SERVE0) & space;
   assign bus.ready1 = (state == SERVE1) & space;
   assign accept0    = bus.ready0 & bus.valid0;
   assign accept1    = bus.ready1 & bus.valid1;
   assign load       = accept0 | accept1;
   assign din        = accept1 ? bus.In1 : bus.In0;
   assign bus.grant  = grant_q;

   // Lane-relative view of the current grant so both SERVE states share one rule set.
   assign own_v = (state == SERVE1) ? bus.valid1 : bus.valid0;
   assign oth_v = (state == SERVE1) ? bus.valid0 : bus.valid1;
   assign oth_s = (state == SERVE1) ? SERVE0 : SERVE1;

   // Next-state, burst counter and last-served pointer.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      if (load) last_nxt = accept1;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (bus.valid0 && bus.valid1) state_nxt = last ? SERVE0 : SERVE1;
            else if (bus.valid0)          state_nxt = SERVE0;
            else if (bus.valid1)          state_nxt = SERVE1;
         end
         SERVE0, SERVE1: begin
            if (!own_v) begin
               cnt_nxt   = '0;
               state_nxt = oth_v ? oth_s : IDLE;
            end else if (load) begin
               if (cnt == CNT_END) begin
                  // Burst over: hand off only if the other lane is waiting, else start a new burst.
                  cnt_nxt = '0;
                  if (oth_v) state_nxt = oth_s;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM registers; grant is registered from the next state so it mirrors state exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         last    <= 1'b1;
         cnt     <= '0;
         grant_q <= GRANT_NONE;
      end else begin
         state   <= state_nxt;
         last    <= last_nxt;
         cnt     <= cnt_nxt;
         grant_q <= grant_de(state_nxt);
      end
   end

   registro_salida_rv u_registro_salida_rv (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .din       (din),
      .out_ready (bus.out_ready),
      .dout      (bus.data_out),
      .out_valid (bus.outValid)
   );

endmodule
